acc_op_issuer: RTL and testbench
================================

Name: acc_op_issuer

Overview:
- Producer side of the `registers` command interface (instr/input_val/clk_en).
- Accepts high-level ACC operations from the node decoder over a valid/ready handshake: MOV-to-ACC, ADD, SUB, NEG, SAV, SWP, NOP.
- Fetches blocking source operands from a port, computes TIS-100 saturated arithmetic against the current ACC value, and drives one `registers` command per accepted op.
- Sits between the instruction decoder and the `registers` instance inside each node.

Parameters:
- WIDTH, 11, data width of ACC/operands; two's-complement signed.
- SAT_MAX, 999, saturation magnitude; results are clamped to [-SAT_MAX, +SAT_MAX].

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clk_en  input  1  global step enable; when 0 all state holds and reg_en=0
- op_valid  input  1  op request present
- op_ready  output  1  block can accept an op this cycle
- op_code  input  3  0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 NEG, 5 SAV, 6 SWP, 7 reserved (treated as NOP)
- op_use_port  input  1  operand comes from port (blocking), else op_imm
- op_imm  input  WIDTH  immediate operand, signed
- src_valid  input  1  port operand available
- src_data  input  WIDTH  port operand, signed
- src_ack  output  1  one-cycle pulse consuming src_data
- acc_in  input  WIDTH  current ACC from `registers` out
- reg_instr  output  2  `registers` instr: 00 hold, 01 load ACC from reg_val, 10 SAV (BAK<=ACC), 11 SWP
- reg_val  output  WIDTH  value loaded into ACC when reg_instr=01
- reg_en  output  1  drives `registers` clk_en; high for exactly one cycle per issued command
- flag_z  output  1  registered: last issued ACC value == 0
- flag_n  output  1  registered: last issued ACC value < 0

Behaviour:
- Reset: state=IDLE, op_ready=0 during reset and 1 on the first clk_en cycle after it; src_ack=0, reg_instr=00, reg_val=0, reg_en=0, flag_z=1, flag_n=0. Reset overrides clk_en.
- All transitions are qualified by clk_en. With clk_en=0: state, outputs and latched op hold, except reg_en and src_ack, which are forced to 0.
- States: IDLE, WAIT_SRC, ISSUE.
- IDLE: op_ready=1. On op_valid:
  - Latch the op.
  - Go to WAIT_SRC if op_use_port=1 and op_code is MOV/ADD/SUB; otherwise go to ISSUE.
  - NEG/SAV/SWP/NOP ignore the operand and never touch the port.
- WAIT_SRC: op_ready=0. When src_valid=1, pulse src_ack for one cycle, latch src_data, go to ISSUE. Waits indefinitely; no timeout.
- ISSUE: op_ready=0. For one cycle drive reg_en=1 with:
  - MOV: reg_instr=01, reg_val=sat(operand)
  - ADD: reg_instr=01, reg_val=sat(acc_in+operand)
  - SUB: reg_instr=01, reg_val=sat(acc_in-operand)
  - NEG: reg_instr=01, reg_val=-acc_in
  - SAV: reg_instr=10
  - SWP: reg_instr=11
  - NOP: reg_instr=00
  - Then return to IDLE.
- Arithmetic: sum/difference computed in WIDTH+1 bits; sat() clamps to ±SAT_MAX. The result always fits WIDTH.
- Flags: update on the ISSUE cycle from reg_val for 01 commands. SAV/NOP leave flags unchanged. SWP flags are updated one cycle later from acc_in.
- Throughput and latency:
  - Immediate op: accepted in cycle N, reg_en in cycle N+1, op_ready high again in N+2.
  - Port op: reg_en one cycle after the src_ack cycle.
- reset mid-WAIT_SRC: the pending op is dropped; src_ack is not asserted.
- src_valid is ignored outside WAIT_SRC.
- op_valid is ignored while op_ready=0; the decoder must hold it.

Optional Feature:
- Macro ACC_SAT_FLAG_EN.
- When defined: add output flag_sat (1 bit), sticky high once any ADD/SUB/MOV result was clamped. Cleared only by reset.
- When undefined: the port does not exist and there is no clamp-detect logic. Arithmetic still saturates.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, clk_en=1 -> reg_en=0, reg_instr=00, flag_z=1, op_ready=1 after reset release.
- Immediate chain from acc_in=0:
  - MOV 5 -> reg_instr=01, reg_val=5 one cycle after accept.
  - ADD 7 (acc_in=5) -> reg_val=12.
  - SUB 20 (acc_in=12) -> reg_val=-8, flag_n=1, flag_z=0.
- Saturation:
  - acc_in=990, ADD 50 -> reg_val=999.
  - acc_in=-990, SUB 50 -> reg_val=-999; flag_sat=1 with ACC_SAT_FLAG_EN.
  - MOV -1000 -> reg_val=-999.
- Blocking port:
  - ADD from port with src_valid=0 for 6 cycles -> op_ready=0, reg_en=0 throughout.
  - src_valid=1, src_data=3, acc_in=4 -> src_ack pulse, next cycle reg_val=7, reg_en=1.
- SAV/SWP/NEG:
  - SAV -> reg_instr=10.
  - SWP -> reg_instr=11.
  - NEG with acc_in=-999 -> reg_val=999, flag_n=0.
  - Each has exactly one reg_en pulse.
- Stall and reset mid-op:
  - clk_en=0 during ISSUE -> reg_en held 0 and the command is issued when clk_en returns.
  - reset in WAIT_SRC -> IDLE, no src_ack, no reg_en.

Source files
------------

// File: rtl/acc_op_issuer_if.sv
// Command-issue bundle between the node decoder, source port, and `registers`.
// flag_sat exists only when ACC_SAT_FLAG_EN is defined.
interface acc_op_issuer_if #(
    parameter int WIDTH = 11
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic             op_use_port;
    logic [WIDTH-1:0] op_imm;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_ack;
    logic [WIDTH-1:0] acc_in;
    logic [1:0]       reg_instr;
    logic [WIDTH-1:0] reg_val;
    logic             reg_en;
    logic             flag_z;
    logic             flag_n;
`ifdef ACC_SAT_FLAG_EN
    logic             flag_sat;
`endif

    modport master (
        input  op_valid, op_code, op_use_port, op_imm, src_valid, src_data, acc_in,
        output op_ready, src_ack, reg_instr, reg_val, reg_en, flag_z, flag_n
`ifdef ACC_SAT_FLAG_EN
        , output flag_sat
`endif
    );

    modport slave (
        output op_valid, op_code, op_use_port, op_imm, src_valid, src_data, acc_in,
        input  op_ready, src_ack, reg_instr, reg_val, reg_en, flag_z, flag_n
`ifdef ACC_SAT_FLAG_EN
        , input flag_sat
`endif
    );
endinterface

// File: rtl/acc_op_issuer.sv
// ACC op issuer: accepts decoder ops, fetches blocking port operands, and drives one
// saturated `registers` command per op. Define ACC_SAT_FLAG_EN for the sticky flag_sat.
module acc_op_issuer #(
    parameter int WIDTH   = 11,
    parameter int SAT_MAX = 999
) (
    input logic             clk,
    input logic             reset,
    input logic             clk_en,
    acc_op_issuer_if.master bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SRC = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_NEG = 3'd4;
    localparam logic [2:0] OP_SAV = 3'd5;
    localparam logic [2:0] OP_SWP = 3'd6;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_SAV  = 2'b10;
    localparam logic [1:0] CMD_SWP  = 2'b11;

    localparam logic signed [WIDTH:0] SAT_HI = (WIDTH+1)'(SAT_MAX);
    localparam logic signed [WIDTH:0] SAT_LO = -SAT_HI;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_code_q, op_code_d;
    logic [1:0]       reg_instr_q, reg_instr_d;
    logic [WIDTH-1:0] reg_val_q, reg_val_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             swp_pend_q, swp_pend_d;
`ifdef ACC_SAT_FLAG_EN
    logic             sat_q, sat_d;
`endif

    logic                    op_ready, src_ack, reg_en, load, is_arith;
    logic [2:0]              op_sel;
    logic [WIDTH-1:0]        opnd_sel, sat_val;
    logic signed [WIDTH:0]   acc_x, opnd_x, raw;
    logic [1:0]              cmd;

    assign op_ready = (state_q == S_IDLE) && !reset;
    assign src_ack  = (state_q == S_WAIT_SRC) && bus.src_valid && clk_en && !reset;
    assign reg_en   = (state_q == S_ISSUE) && clk_en && !reset;

    // The result is computed on the cycle the operand becomes available (accept or
    // src_ack) and registered, so no separate operand latch is needed.
    always_comb begin
        op_sel   = (state_q == S_IDLE) ? bus.op_code : op_code_q;
        opnd_sel = (state_q == S_IDLE) ? bus.op_imm : bus.src_data;
        acc_x    = $signed({bus.acc_in[WIDTH-1], bus.acc_in});
        opnd_x   = $signed({opnd_sel[WIDTH-1], opnd_sel});
        is_arith = (op_sel == OP_MOV) || (op_sel == OP_ADD) || (op_sel == OP_SUB);
        raw      = acc_x;
        cmd      = CMD_HOLD;
        case (op_sel)
            OP_MOV: begin raw = opnd_x;          cmd = CMD_LOAD; end
            OP_ADD: begin raw = acc_x + opnd_x;  cmd = CMD_LOAD; end
            OP_SUB: begin raw = acc_x - opnd_x;  cmd = CMD_LOAD; end
            OP_NEG: begin raw = -acc_x;          cmd = CMD_LOAD; end
            OP_SAV: cmd = CMD_SAV;
            OP_SWP: cmd = CMD_SWP;
            default: cmd = CMD_HOLD;
        endcase
        if (raw > SAT_HI)      sat_val = SAT_HI[WIDTH-1:0];
        else if (raw < SAT_LO) sat_val = SAT_LO[WIDTH-1:0];
        else                   sat_val = raw[WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        op_code_d   = op_code_q;
        reg_instr_d = reg_instr_q;
        reg_val_d   = reg_val_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        swp_pend_d  = swp_pend_q;
`ifdef ACC_SAT_FLAG_EN
        sat_d       = sat_q;
`endif
        load        = 1'b0;
        if (clk_en) begin
            // SWP flags follow the swapped ACC, visible one cycle after the issue.
            if (swp_pend_q) begin
                flag_z_d   = (bus.acc_in == '0);
                flag_n_d   = bus.acc_in[WIDTH-1];
                swp_pend_d = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        op_code_d = bus.op_code;
                        if (bus.op_use_port && is_arith) begin
                            state_d = S_WAIT_SRC;
                        end else begin
                            state_d = S_ISSUE;
                            load    = 1'b1;
                        end
                    end
                end
                S_WAIT_SRC: begin
                    if (src_ack) begin
                        state_d = S_ISSUE;
                        load    = 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_d = S_IDLE;
                    if (reg_instr_q == CMD_LOAD) begin
                        flag_z_d = (reg_val_q == '0);
                        flag_n_d = reg_val_q[WIDTH-1];
                    end
                    if (reg_instr_q == CMD_SWP) swp_pend_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (load) begin
                reg_instr_d = cmd;
                if (cmd == CMD_LOAD) reg_val_d = sat_val;
`ifdef ACC_SAT_FLAG_EN
                if (is_arith && (raw > SAT_HI || raw < SAT_LO)) sat_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_code_q   <= OP_NOP;
            reg_instr_q <= CMD_HOLD;
            reg_val_q   <= '0;
            flag_z_q    <= 1'b1;
            flag_n_q    <= 1'b0;
            swp_pend_q  <= 1'b0;
`ifdef ACC_SAT_FLAG_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_code_q   <= op_code_d;
            reg_instr_q <= reg_instr_d;
            reg_val_q   <= reg_val_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            swp_pend_q  <= swp_pend_d;
`ifdef ACC_SAT_FLAG_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.src_ack   = src_ack;
    assign bus.reg_en    = reg_en;
    assign bus.reg_instr = reg_instr_q;
    assign bus.reg_val   = reg_val_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_n    = flag_n_q;
`ifdef ACC_SAT_FLAG_EN
    assign bus.flag_sat  = sat_q;
`endif
endmodule

// File: tb/tb_acc_op_issuer.sv
// Bench for acc_op_issuer: vector table of immediate ops plus hand sequences for port
// blocking, clk_en stalls, SWP flag timing and reset mid-op; a scoreboard checks each reg_en.
module tb_acc_op_issuer;
    localparam int W = 11;

    typedef struct {
        logic [2:0] code;
        int         imm;
        int         acc;
        logic [1:0] instr;
        int         val;
        logic       z;
        logic       n;
    } vec_t;

    typedef struct {
        logic [1:0] instr;
        int         val;
    } exp_t;

    logic clk, reset, clk_en;
    int   checks, errors, pulses;
    exp_t sb[$];
    vec_t vecs[12];

    acc_op_issuer_if #(.WIDTH(W)) bus ();

    acc_op_issuer #(.WIDTH(W), .SAT_MAX(999)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every reg_en pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.reg_en) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL reg_en_unexpected actual=1 required=0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("reg_instr", int'(bus.reg_instr), int'(e.instr));
                if (e.instr == 2'b01) chk("reg_val", int'($signed(bus.reg_val)), e.val);
            end
        end
    end

    // Called #1 after a posedge with the DUT idle; returns #1 after the post-issue edge.
    task automatic run_op(input logic [2:0] code, input int imm, input int acc,
                          input logic [1:0] ei, input int ev);
        int p0;
        exp_t e;
        chk("op_ready_idle", int'(bus.op_ready), 1);
        bus.op_valid    = 1'b1;
        bus.op_code     = code;
        bus.op_use_port = 1'b0;
        bus.op_imm      = W'(imm);
        bus.acc_in      = W'(acc);
        e.instr = ei;
        e.val   = ev;
        sb.push_back(e);
        p0 = pulses;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        chk("op_ready_busy", int'(bus.op_ready), 0);
        chk("reg_en_latency", int'(bus.reg_en), 1);
        @(posedge clk); #1;
        chk("reg_en_pulses", pulses - p0, 1);
    endtask

    initial begin
        exp_t e;
        checks = 0; errors = 0; pulses = 0;
        vecs[0]  = '{3'd1,    5,    0, 2'b01,    5, 1'b0, 1'b0};
        vecs[1]  = '{3'd2,    7,    5, 2'b01,   12, 1'b0, 1'b0};
        vecs[2]  = '{3'd3,   20,   12, 2'b01,   -8, 1'b0, 1'b1};
        vecs[3]  = '{3'd2,   50,  990, 2'b01,  999, 1'b0, 1'b0};
        vecs[4]  = '{3'd3,   50, -990, 2'b01, -999, 1'b0, 1'b1};
        vecs[5]  = '{3'd1, -1000,   0, 2'b01, -999, 1'b0, 1'b1};
        vecs[6]  = '{3'd4,    0, -999, 2'b01,  999, 1'b0, 1'b0};
        vecs[7]  = '{3'd1,    0,    5, 2'b01,    0, 1'b1, 1'b0};
        vecs[8]  = '{3'd5,    0,    3, 2'b10,    0, 1'b1, 1'b0};
        vecs[9]  = '{3'd0,    0,    3, 2'b00,    0, 1'b1, 1'b0};
        vecs[10] = '{3'd7,    0,    3, 2'b00,    0, 1'b1, 1'b0};
        vecs[11] = '{3'd2, -500, -600, 2'b01, -999, 1'b0, 1'b1};

        bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_use_port = 1'b0; bus.op_imm = '0;
        bus.src_valid = 1'b0; bus.src_data = '0; bus.acc_in = '0;
        reset = 1'b1; clk_en = 1'b1;

        @(posedge clk); #1;
        chk("rst_op_ready", int'(bus.op_ready), 0);
        chk("rst_reg_en", int'(bus.reg_en), 0);
        chk("rst_reg_instr", int'(bus.reg_instr), 0);
        chk("rst_reg_val", int'(bus.reg_val), 0);
        chk("rst_flag_z", int'(bus.flag_z), 1);
        chk("rst_flag_n", int'(bus.flag_n), 0);
`ifdef ACC_SAT_FLAG_EN
        chk("rst_flag_sat", int'(bus.flag_sat), 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("op_ready_after_rst", int'(bus.op_ready), 1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].code, vecs[i].imm, vecs[i].acc, vecs[i].instr, vecs[i].val);
            chk("flag_z", int'(bus.flag_z), int'(vecs[i].z));
            chk("flag_n", int'(bus.flag_n), int'(vecs[i].n));
`ifdef ACC_SAT_FLAG_EN
            chk("flag_sat", int'(bus.flag_sat), (i >= 3) ? 1 : 0);
`endif
        end

        // SWP: flags unchanged on the issue edge, then taken from the swapped ACC.
        run_op(3'd6, 0, 42, 2'b11, 0);
        chk("swp_flag_z_hold", int'(bus.flag_z), 0);
        chk("swp_flag_n_hold", int'(bus.flag_n), 1);
        bus.acc_in = '0;
        @(posedge clk); #1;
        chk("swp_flag_z", int'(bus.flag_z), 1);
        chk("swp_flag_n", int'(bus.flag_n), 0);

        // Port operand: src_valid ignored in IDLE, then a 6-cycle block.
        bus.acc_in = W'(4); bus.src_valid = 1'b1; bus.src_data = W'(77);
        #1;
        chk("src_ack_idle", int'(bus.src_ack), 0);
        bus.src_valid = 1'b0;
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.op_use_port = 1'b1; bus.op_imm = W'(100);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("wait_op_ready", int'(bus.op_ready), 0);
            chk("wait_reg_en", int'(bus.reg_en), 0);
            chk("wait_src_ack", int'(bus.src_ack), 0);
            @(posedge clk); #1;
        end
        e.instr = 2'b01; e.val = 7;
        sb.push_back(e);
        bus.src_valid = 1'b1; bus.src_data = W'(3);
        #1;
        chk("src_ack_pulse", int'(bus.src_ack), 1);
        chk("reg_en_at_ack", int'(bus.reg_en), 0);
        @(posedge clk); #1;
        bus.src_valid = 1'b0;
        chk("src_ack_done", int'(bus.src_ack), 0);
        chk("port_reg_en", int'(bus.reg_en), 1);
        @(posedge clk); #1;
        chk("port_op_ready", int'(bus.op_ready), 1);
        chk("port_flag_z", int'(bus.flag_z), 0);

        // clk_en low during ISSUE: command held back until clk_en returns.
        bus.acc_in = '0;
        bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.op_use_port = 1'b0; bus.op_imm = W'(-9);
        e.instr = 2'b01; e.val = -9;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        clk_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_reg_en", int'(bus.reg_en), 0);
            chk("stall_op_ready", int'(bus.op_ready), 0);
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        #1;
        chk("stall_release_reg_en", int'(bus.reg_en), 1);
        @(posedge clk); #1;
        chk("stall_op_ready_back", int'(bus.op_ready), 1);
        chk("stall_flag_n", int'(bus.flag_n), 1);

        // Reset while waiting on the port drops the op.
        bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.op_use_port = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        reset = 1'b1; bus.src_valid = 1'b1; bus.src_data = W'(5);
        #1;
        chk("rstwait_src_ack", int'(bus.src_ack), 0);
        chk("rstwait_reg_en", int'(bus.reg_en), 0);
        chk("rstwait_op_ready", int'(bus.op_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0; bus.src_valid = 1'b0;
        #1;
        chk("rstwait_idle", int'(bus.op_ready), 1);
        chk("rstwait_flag_z", int'(bus.flag_z), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
